data_mem_responder: RTL and testbench

- Memory-side responder for the core's load/store port, the slave end of the data-memory interface.
- Accepts one request at a time over a valid/ready handshake and performs byte, halfword or word reads and writes on an internal word array.
- Returns read data sign- or zero-extended according to the RISC-V funct3 size code, after a fixed programmable latency.
- Flags misaligned and out-of-range accesses with an error response.

---
 rtl/data_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Slave end of the core's data-memory port. Accepts one load/store at a
//   time over a valid/ready handshake, performs byte/half/word accesses on an
//   internal word array and answers after a fixed LATENCY with extended read
//   data or an error flag.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_wen         1 = store, 0 = load
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   req_size        RISC-V funct3 size code (b, h, w, bu, hu)
//   resp_valid/ready response handshake
//   resp_rdata      extended load data, 0 for stores and errors
//   resp_err        misaligned, out-of-range or illegal-size access
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic        err_reg;
    logic        load_reg;
    logic [1:0]  lane_reg;
    logic [2:0]  size_reg;
    logic [31:0] rd_word_reg;

    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          size_bad;
    logic          misaligned;
    logic          req_err;
    logic          accept;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_rep;

    // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets
    // and are therefore caught by the same range compare.
    assign offset       = req_addr - BASE_ADDR;
    assign out_of_range = (offset >= SPAN);
    assign idx          = offset[AW+1:2];

    assign size_bad   = (req_size == 3'b011) || (req_size == 3'b110) ||
                        (req_size == 3'b111) || (req_wen && req_size[2]);
    assign misaligned = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_size[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_err    = out_of_range || size_bad || misaligned;
    assign accept     = req_valid && req_ready_reg;

    // Per-lane enables and store data replicated so each lane sees the
    // right source byte whatever the access size.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign byte_en[gi] = (req_size[1:0] == 2'b10) ||
                                 ((req_size[1:0] == 2'b01) && (req_addr[1] == LANE[1])) ||
                                 ((req_size[1:0] == 2'b00) && (req_addr[1:0] == LANE));
            assign wdata_rep[gi*8 +: 8] =
                (req_size[1:0] == 2'b10) ? req_wdata[gi*8 +: 8] :
                (req_size[1:0] == 2'b01) ? req_wdata[(gi % 2)*8 +: 8] :
                                           req_wdata[7:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Word array: byte-masked write and registered read, both at the
    // acceptance edge. Contents survive reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept && !req_err) begin
            if (req_wen) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) begin
                        mem[idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
                    end
                end
            end else begin
                rd_word_reg <= mem[idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 4'd0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
            load_reg       <= 1'b0;
            lane_reg       <= 2'd0;
            size_reg       <= 3'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        err_reg       <= req_err;
                        load_reg      <= !req_wen && !req_err;
                        lane_reg      <= req_addr[1:0];
                        size_reg      <= req_size;
                        if (LATENCY == 1) begin
                            state_reg      <= S_RESP;
                            resp_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= S_WAIT;
                            cnt_reg   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_reg == 4'd1) begin
                        state_reg      <= S_RESP;
                        resp_valid_reg <= 1'b1;
                        cnt_reg        <= 4'd0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_reg      <= S_IDLE;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        err_reg        <= 1'b0;
                        load_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= S_IDLE;
                    resp_valid_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response data: lane select and extension of the held read word.
    // Everything feeding this is registered, so it is stable through RESP.
    // ------------------------------------------------------------------
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data;

    assign sel_byte = rd_word_reg[lane_reg*8 +: 8];
    assign sel_half = lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

    always_comb begin
        ext_data = rd_word_reg;
        case (size_reg)
            3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  ext_data = {24'd0, sel_byte};
            3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  ext_data = {16'd0, sel_half};
            default: ext_data = rd_word_reg;
        endcase
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_valid_reg && err_reg;
    assign resp_rdata = (resp_valid_reg && load_reg) ? ext_data : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        resp_ready;
    int          sel;

    logic        vin  [3];
    logic        rdy  [3];
    logic        rv   [3];
    logic        re   [3];
    logic [31:0] rd   [3];

    always #5 clk = ~clk;

    assign vin[0] = req_valid && (sel == 0);
    assign vin[1] = req_valid && (sel == 1);
    assign vin[2] = req_valid && (sel == 2);

    data_mem_responder #(.LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(vin[0]), .req_ready(rdy[0]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .resp_valid(rv[0]), .resp_ready(resp_ready),
        .resp_rdata(rd[0]), .resp_err(re[0]));

    data_mem_responder #(.LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(vin[1]), .req_ready(rdy[1]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .resp_valid(rv[1]), .resp_ready(resp_ready),
        .resp_rdata(rd[1]), .resp_err(re[1]));

    data_mem_responder #(.LATENCY(15)) u_lat15 (
        .clk(clk), .rst(rst), .req_valid(vin[2]), .req_ready(rdy[2]),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .resp_valid(rv[2]), .resp_ready(resp_ready),
        .resp_rdata(rd[2]), .resp_err(re[2]));

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          lat;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] ed;
        logic        ee;
        int          hold;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[20];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // One complete transaction on instance s; hold = extra cycles of
    // response backpressure.
    task automatic xact(input int s, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        input logic [31:0] ed, input logic ee, input int hold);
        exp_t e;
        int   n;
        exp_q.push_back('{d: ed, e: ee, lat: (s == 0) ? 2 : (s == 1) ? 1 : 15});
        @(negedge clk);
        sel = s; req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_valid = 1'b1;
        n = 0;
        while (!rdy[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_accept", 32'(rdy[s]), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rv[s] && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        chk("latency", 32'(n), 32'(e.lat));
        chk("rdata", rd[s], e.d);
        chk("err", 32'(re[s]), 32'(e.e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rv[s]), 32'd1);
            chk("hold_rdata", rd[s], e.d);
            chk("hold_err", 32'(re[s]), 32'(e.e));
            chk("hold_req_ready", 32'(rdy[s]), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("idle_req_ready", 32'(rdy[s]), 32'd1);
        chk("idle_resp_valid", 32'(rv[s]), 32'd0);
        $display("xact inst=%0d wen=%0d addr=%h wdata=%h size=%0d -> rdata=%h err=%0d lat=%0d",
                 s, wen, addr, wdata, size, e.d, e.e, n);
    endtask

    initial begin
        // wen, addr, wdata, size, expected rdata, expected err, hold
        vt[0]  = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, SZ_W,  32'h0000_0000, 1'b0, 0};
        vt[1]  = '{1'b0, 32'h8000_0000, 32'h0,         SZ_W,  32'hDEAD_BEEF, 1'b0, 5};
        vt[2]  = '{1'b1, 32'h8000_0004, 32'h1122_3344, SZ_W,  32'h0000_0000, 1'b0, 0};
        vt[3]  = '{1'b1, 32'h8000_0005, 32'h0000_0080, SZ_B,  32'h0000_0000, 1'b0, 0};
        vt[4]  = '{1'b0, 32'h8000_0005, 32'h0,         SZ_B,  32'hFFFF_FF80, 1'b0, 0};
        vt[5]  = '{1'b0, 32'h8000_0005, 32'h0,         SZ_BU, 32'h0000_0080, 1'b0, 0};
        vt[6]  = '{1'b0, 32'h8000_0004, 32'h0,         SZ_HU, 32'h0000_8044, 1'b0, 0};
        vt[7]  = '{1'b0, 32'h8000_0004, 32'h0,         SZ_H,  32'hFFFF_8044, 1'b0, 0};
        vt[8]  = '{1'b0, 32'h8000_0003, 32'h0,         SZ_H,  32'h0000_0000, 1'b1, 2};
        vt[9]  = '{1'b0, 32'h8000_0000, 32'h0,         SZ_W,  32'hDEAD_BEEF, 1'b0, 0};
        vt[10] = '{1'b1, 32'h8000_1000, 32'h5555_5555, SZ_W,  32'h0000_0000, 1'b1, 0};
        vt[11] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         SZ_W,  32'h0000_0000, 1'b1, 0};
        vt[12] = '{1'b1, 32'h8000_0006, 32'h0000_ABCD, SZ_H,  32'h0000_0000, 1'b0, 0};
        vt[13] = '{1'b0, 32'h8000_0004, 32'h0,         SZ_W,  32'hABCD_8044, 1'b0, 0};
        vt[14] = '{1'b0, 32'h8000_0004, 32'h0,         3'b011, 32'h0000_0000, 1'b1, 0};
        vt[15] = '{1'b1, 32'h8000_0004, 32'h0000_0077, SZ_BU, 32'h0000_0000, 1'b1, 0};
        vt[16] = '{1'b0, 32'h8000_0006, 32'h0,         SZ_HU, 32'h0000_ABCD, 1'b0, 0};
        vt[17] = '{1'b0, 32'h8000_0007, 32'h0,         SZ_B,  32'hFFFF_FFAB, 1'b0, 0};
        vt[18] = '{1'b1, 32'h8000_0FFC, 32'h0F0F_0F0F, SZ_W,  32'h0000_0000, 1'b0, 0};
        vt[19] = '{1'b0, 32'h8000_0FFC, 32'h0,         SZ_W,  32'h0F0F_0F0F, 1'b0, 0};

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_size = 3'b0; resp_ready = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(rdy[0]), 32'd1);
        chk("reset_resp_valid", 32'(rv[0]), 32'd0);
        chk("reset_rdata", rd[0], 32'd0);
        chk("reset_err", 32'(re[0]), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            xact(0, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].ed, vt[i].ee, vt[i].hold);
        end
        // The errored sb must have left the word alone.
        xact(0, 1'b0, 32'h8000_0004, 32'h0, SZ_W, 32'hABCD_8044, 1'b0, 0);

        // Reset while waiting: no response, but the store stays committed.
        @(negedge clk);
        sel = 0; req_wen = 1'b1; req_addr = 32'h8000_0010;
        req_wdata = 32'h1234_5678; req_size = SZ_W; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req_ready", 32'(rdy[0]), 32'd1);
        chk("abort_resp_valid", 32'(rv[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(rv[0]), 32'd0);
        end
        $display("xact inst=0 reset during WAIT after sw 80000010");
        xact(0, 1'b0, 32'h8000_0010, 32'h0, SZ_W, 32'h1234_5678, 1'b0, 0);

        // Latency extremes.
        xact(1, 1'b1, 32'h8000_0100, 32'hCAFE_F00D, SZ_W, 32'h0, 1'b0, 0);
        xact(1, 1'b0, 32'h8000_0100, 32'h0, SZ_W, 32'hCAFE_F00D, 1'b0, 1);
        xact(2, 1'b1, 32'h8000_0200, 32'h0BAD_F00D, SZ_W, 32'h0, 1'b0, 0);
        xact(2, 1'b0, 32'h8000_0202, 32'h0, SZ_H, 32'h0000_0BAD, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
